time_set_editor: RTL
====================

// Module: time_set_editor
// PURPOSE
//  Upstream editor for the running time-keeper. Turns debounced single-cycle button pulses into
//  the keeper's load bus (year_d..sec_d, week_s) and its mode select (0 = load, nonzero = run).
//  On entry to set mode it snapshots the live time, then lets the user step through fields and
//  inc/dec each with calendar-correct wrap and clamping. Also drives field-select and blink
//  outputs for the display stage.
// PARAMETERS
//  YEAR_MIN     2000         lowest settable year
//  YEAR_MAX     2099         highest settable year
//  BLINK_HALF   50_000_000   clk cycles per blink half-period
//  TIMEOUT_CYC  1_500_000_000  idle clk cycles in set mode before auto-exit (0 = disabled)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  btn_mode   in   1   1-cycle pulse: enter/leave set mode
//  btn_next   in   1   1-cycle pulse: advance to next field
//  btn_up     in   1   1-cycle pulse: increment current field
//  btn_down   in   1   1-cycle pulse: decrement current field
//  cur_year   in   16  live year from keeper (snapshot source); likewise cur_month[5:0],
//  cur_day/cur_hour/cur_minute/cur_second/cur_week in 11 each (low bits used)
//  year_d     out  15  load value: year
//  month_d    out  4   load value: month 1..12
//  day_d      out  5   load value: day 1..days_in_month
//  hour_d     out  6   0..23;  min_d out 6 0..59;  sec_d out 6 0..59
//  week_s     out  4   1..7
//  mode       out  4   4'd0 while editing (keeper loads), 4'd1 while running
//  edit_field out  3   0=none,1=year,2=month,3=day,4=hour,5=min,6=sec,7=week
//  blink      out  1   toggles every BLINK_HALF cycles in set mode; 1 in RUN
// BEHAVIOUR
//  - Reset (async, rst_n=0): state RUN, mode=1, edit_field=0, blink=1, counters 0;
//    load regs = 2023/5/9 11:59:58 week 2.
//  - FSM: RUN -> S_YEAR on btn_mode; S_YEAR->S_MONTH->S_DAY->S_HOUR->S_MIN->S_SEC->S_WEEK->S_YEAR
//    on btn_next; any S_* -> RUN on btn_mode or idle-timeout expiry.
//  - RUN->S_YEAR edge: all load regs capture cur_* (truncated) on that same edge; mode=0 from
//    the next cycle. Snapshot never overrides later edits.
//  - All outputs registered; one-cycle latency from pulse to output change.
//  - Button priority in one cycle: btn_mode > btn_next > btn_up/btn_down; up+down together = no-op.
//  - Up/down wrap: year YEAR_MAX<->YEAR_MIN, month 12<->1, day dim<->1, hour 23<->0,
//    min/sec 59<->0, week 7<->1.
//  - dim: 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb 29 if (y%4==0 && y%100!=0)||y%400==0, else 28.
//  - Clamp: same edge a month or year edit makes day > new dim, day_d = new dim.
//  - sec_d edit does not touch other fields (no carry); likewise every field.
//  - Idle counter clears on any button pulse and on RUN entry; at TIMEOUT_CYC-1 forces RUN.
//  - Blink counter runs only in set mode; cleared and blink=1 on entering RUN, and restarts
//    at 0 with blink=1 on each btn_next so the new field is visible immediately.
//  - Reset mid-edit: unconditionally back to reset state; partial edits discarded.
//  - Out-of-range snapshot values (e.g. day 0) clamp into range on capture.
// TESTING
//  1 Reset, cur=2024/2/10 08:30:15 wk6, pulse btn_mode -> next cycle mode=0, edit_field=1, load bus=snapshot.
//  2 Snapshot 2024/1/31; btn_next, btn_up (month->2) -> day_d=29; set year 2023 -> day_d=28.
//  3 In S_MIN with min_d=59, btn_up -> min_d=0, hour_d unchanged; btn_down -> 59.
//  4 S_YEAR at 2099, btn_up -> 2000; btn_up+btn_down same cycle -> unchanged; btn_mode+btn_up -> RUN, year unchanged.
//  5 TIMEOUT_CYC=100, enter set mode, no buttons 100 cycles -> mode=1, edit_field=0.
//  6 Assert rst_n=0 mid-edit in S_DAY -> immediately mode=1, edit_field=0, load regs=2023/5/9 11:59:58 wk2.

Source files
------------

// File: rtl/time_set_editor.sv
// Set-mode editor feeding the time-keeper load bus: snapshot on entry, per-field wrap/clamp edits.
// Latency: one cycle from button pulse to registered output. No backpressure; every pulse is consumed.
module time_set_editor #(
    parameter int unsigned YEAR_MIN    = 2000,
    parameter int unsigned YEAR_MAX    = 2099,
    parameter int unsigned BLINK_HALF  = 50_000_000,
    parameter int unsigned TIMEOUT_CYC = 1_500_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_mode,
    input  logic        btn_next,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [15:0] cur_year,
    input  logic [5:0]  cur_month,
    input  logic [10:0] cur_day,
    input  logic [10:0] cur_hour,
    input  logic [10:0] cur_minute,
    input  logic [10:0] cur_second,
    input  logic [10:0] cur_week,
    output logic [14:0] year_d,
    output logic [3:0]  month_d,
    output logic [4:0]  day_d,
    output logic [5:0]  hour_d,
    output logic [5:0]  min_d,
    output logic [5:0]  sec_d,
    output logic [3:0]  week_s,
    output logic [3:0]  mode,
    output logic [2:0]  edit_field,
    output logic        blink
);
    localparam logic [2:0] RUN     = 3'd0;
    localparam logic [2:0] S_YEAR  = 3'd1;
    localparam logic [2:0] S_MONTH = 3'd2;
    localparam logic [2:0] S_DAY   = 3'd3;
    localparam logic [2:0] S_HOUR  = 3'd4;
    localparam logic [2:0] S_MIN   = 3'd5;
    localparam logic [2:0] S_SEC   = 3'd6;
    localparam logic [2:0] S_WEEK  = 3'd7;

    localparam logic [15:0] Y_LO         = 16'(YEAR_MIN);
    localparam logic [15:0] Y_HI         = 16'(YEAR_MAX);
    localparam logic [31:0] BLINK_LAST   = 32'(BLINK_HALF - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    function automatic logic [4:0] dim_f(input logic [14:0] y, input logic [3:0] m);
        logic leap;
        leap = (((y % 15'd4) == 15'd0) && ((y % 15'd100) != 15'd0)) || ((y % 15'd400) == 15'd0);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: dim_f = 5'd30;
            4'd2:                    dim_f = leap ? 5'd29 : 5'd28;
            default:                 dim_f = 5'd31;
        endcase
    endfunction

    logic [2:0]  state, nx_state;
    logic [31:0] idle_cnt, blink_cnt;
    logic [14:0] nx_year, snap_year;
    logic [3:0]  nx_month, snap_month, nx_week, snap_week;
    logic [4:0]  nx_day, snap_day, snap_dim, dim_lim;
    logic [5:0]  nx_hour, nx_min, nx_sec, snap_hour, snap_min, snap_sec;
    logic        any_btn, step, timeout;

    // Live values are clamped into range before they can become load values.
    always_comb begin
        if (cur_year < Y_LO)      snap_year = Y_LO[14:0];
        else if (cur_year > Y_HI) snap_year = Y_HI[14:0];
        else                      snap_year = cur_year[14:0];
        if (cur_month == 6'd0)     snap_month = 4'd1;
        else if (cur_month > 6'd12) snap_month = 4'd12;
        else                        snap_month = cur_month[3:0];
        snap_dim = dim_f(snap_year, snap_month);
        if (cur_day == 11'd0)                snap_day = 5'd1;
        else if (cur_day > {6'd0, snap_dim}) snap_day = snap_dim;
        else                                 snap_day = cur_day[4:0];
        snap_hour = (cur_hour   > 11'd23) ? 6'd23 : cur_hour[5:0];
        snap_min  = (cur_minute > 11'd59) ? 6'd59 : cur_minute[5:0];
        snap_sec  = (cur_second > 11'd59) ? 6'd59 : cur_second[5:0];
        if (cur_week == 11'd0)     snap_week = 4'd1;
        else if (cur_week > 11'd7) snap_week = 4'd7;
        else                       snap_week = cur_week[3:0];
    end

    always_comb begin
        any_btn  = btn_mode | btn_next | btn_up | btn_down;
        step     = btn_up ^ btn_down;
        timeout  = (TIMEOUT_CYC != 0) && (idle_cnt == TIMEOUT_LAST) && !any_btn;
        nx_state = state;
        nx_year  = year_d;
        nx_month = month_d;
        nx_day   = day_d;
        nx_hour  = hour_d;
        nx_min   = min_d;
        nx_sec   = sec_d;
        nx_week  = week_s;
        dim_lim  = 5'd31;
        if (state == RUN) begin
            if (btn_mode) begin
                nx_state = S_YEAR;
                nx_year  = snap_year;
                nx_month = snap_month;
                nx_day   = snap_day;
                nx_hour  = snap_hour;
                nx_min   = snap_min;
                nx_sec   = snap_sec;
                nx_week  = snap_week;
            end
        end else if (btn_mode || timeout) begin
            nx_state = RUN;
        end else if (btn_next) begin
            nx_state = (state == S_WEEK) ? S_YEAR : state + 3'd1;
        end else if (step) begin
            case (state)
                S_YEAR: begin
                    if (btn_up) nx_year = (year_d == Y_HI[14:0]) ? Y_LO[14:0] : year_d + 15'd1;
                    else        nx_year = (year_d == Y_LO[14:0]) ? Y_HI[14:0] : year_d - 15'd1;
                    dim_lim = dim_f(nx_year, month_d);
                    if (day_d > dim_lim) nx_day = dim_lim;
                end
                S_MONTH: begin
                    if (btn_up) nx_month = (month_d == 4'd12) ? 4'd1 : month_d + 4'd1;
                    else        nx_month = (month_d == 4'd1) ? 4'd12 : month_d - 4'd1;
                    dim_lim = dim_f(year_d, nx_month);
                    if (day_d > dim_lim) nx_day = dim_lim;
                end
                S_DAY: begin
                    dim_lim = dim_f(year_d, month_d);
                    if (btn_up) nx_day = (day_d >= dim_lim) ? 5'd1 : day_d + 5'd1;
                    else        nx_day = (day_d <= 5'd1) ? dim_lim : day_d - 5'd1;
                end
                S_HOUR: begin
                    if (btn_up) nx_hour = (hour_d == 6'd23) ? 6'd0 : hour_d + 6'd1;
                    else        nx_hour = (hour_d == 6'd0) ? 6'd23 : hour_d - 6'd1;
                end
                S_MIN: begin
                    if (btn_up) nx_min = (min_d == 6'd59) ? 6'd0 : min_d + 6'd1;
                    else        nx_min = (min_d == 6'd0) ? 6'd59 : min_d - 6'd1;
                end
                S_SEC: begin
                    if (btn_up) nx_sec = (sec_d == 6'd59) ? 6'd0 : sec_d + 6'd1;
                    else        nx_sec = (sec_d == 6'd0) ? 6'd59 : sec_d - 6'd1;
                end
                S_WEEK: begin
                    if (btn_up) nx_week = (week_s == 4'd7) ? 4'd1 : week_s + 4'd1;
                    else        nx_week = (week_s == 4'd1) ? 4'd7 : week_s - 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            mode      <= 4'd1;
            year_d    <= 15'd2023;
            month_d   <= 4'd5;
            day_d     <= 5'd9;
            hour_d    <= 6'd11;
            min_d     <= 6'd59;
            sec_d     <= 6'd58;
            week_s    <= 4'd2;
            idle_cnt  <= '0;
            blink_cnt <= '0;
            blink     <= 1'b1;
        end else begin
            state   <= nx_state;
            mode    <= (nx_state == RUN) ? 4'd1 : 4'd0;
            year_d  <= nx_year;
            month_d <= nx_month;
            day_d   <= nx_day;
            hour_d  <= nx_hour;
            min_d   <= nx_min;
            sec_d   <= nx_sec;
            week_s  <= nx_week;
            if (nx_state == RUN || any_btn) idle_cnt <= '0;
            else                            idle_cnt <= idle_cnt + 32'd1;
            // A field change restarts the blink phase lit so the new field shows at once.
            if (state == RUN || nx_state == RUN || btn_next) begin
                blink_cnt <= '0;
                blink     <= 1'b1;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + 32'd1;
            end
        end
    end

    assign edit_field = state;

endmodule
